mash_sdm_v2: RTL and testbench
==============================

Name: mash_sdm_v2

Overview:
Parametrised MASH 1-1-1 sigma-delta modulator, the successor to the fixed 3-stage SDM. Input width is a parameter. Order (1, 2 or 3) is selectable at run time, LSB dither is optional, and a clock-enable plus input-valid handshake are added. Sits between the fractional-N control word register and the divider-ratio adder, and emits a signed 4-bit modulus offset each enabled cycle.

Parameters:
W, 16, width of unsigned fractional input and of each stage accumulator (4..32)
LFSR_SEED, 23'h5A5A5A, non-zero reset seed of 23-bit dither LFSR (x^23+x^18+1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
en  in  1  clock enable; all modulator state advances only when high
din_vld  in  1  load strobe for din
din  in  W  unsigned fractional word, value din/2^W
order  in  2  1/2/3 = MASH order; 0 treated as 1
dith_en  in  1  add LFSR bit as carry-in to stage-1 adder
sdm_out  out  4  signed modulus offset, range -3..+4
sdm_vld  out  1  high for one cycle per enabled update
sdm_qn  out  1  MSB of highest active stage accumulator (registered)

Behaviour:
- Reset (rst=1 at edge): din_reg, acc1..acc3, c2_d1, c3_d1, c3_d2, sdm_out and sdm_vld go to 0. sdm_qn goes to 0. order_reg goes to 3. LFSR loads LFSR_SEED. Reset overrides en and din_vld.
- Input: din_vld=1 at an edge loads din_reg. This is independent of en. The new value is used on the next enabled edge.
- Per enabled edge, all combinational within the cycle:
  - s1 = acc1 + din_reg + d, where d = dith_en & lfsr[0]. Width W+1. c1 = s1[W].
  - s2 = acc2 + s1[W-1:0]. c2 = s2[W].
  - s3 = acc3 + s2[W-1:0]. c3 = s3[W].
  - acc_k <= s_k[W-1:0] for active stages. Inactive stages hold 0.
- Noise-shaping combine, signed 4-bit:
  - order 1: y = c1
  - order 2: y = c1 + c2 - c2_d1
  - order 3: y = c1 + c2 - c2_d1 + c3 - 2*c3_d1 + c3_d2
  - Every enabled edge: sdm_out <= y, sdm_vld <= 1, delay regs shift (c2_d1<=c2, c3_d2<=c3_d1, c3_d1<=c3), LFSR advances.
- en=0: all state frozen, sdm_out holds, sdm_vld <= 0.
- Latency: din_vld at edge k gives the first sdm_out reflecting the new din after edge k+1 (2 edges).
- Order change:
  - order is sampled into order_reg each enabled edge.
  - On the edge where order differs from order_reg, accumulators and delay regs of stages above the new order are cleared, and the output uses the new order.
  - acc1 is always preserved.
- Wrap-around: accumulator overflow is the intended carry. No saturation.
- sdm_out never leaves -3..+4. Lower-order modes never produce y outside 0..1 (order 1) or -1..+2 (order 2).
- Long-run mean of sdm_out equals (din + dither mean)/2^W exactly, because the differences telescope.

Decomposition:
- Package mash_sdm_pkg holds:
  - OUT_W=4
  - LFSR_W=23
  - LFSR_TAPS (23, 18)
  - order encodings ORD1/ORD2/ORD3
- One sub-module, mash_acc_stage: a W-bit accumulator with carry-in, carry-out, en and synchronous clr. It is instantiated three times.
- Combine logic and LFSR stay in the top level.

Test Plan:
- W=16, order=1, dith_en=0, din=0x4000 loaded once, en=1 -> sdm_out repeats 0,0,0,1 from the 2nd edge after load; sdm_vld=1 continuously.
- order=3, din=0, dith_en=0 -> sdm_out stays 0 and sdm_qn stays 0 for 1000 cycles.
- order=3, din=0x8000 -> every sample lies in -3..+4; sum of sdm_out over 1024 cycles = 512 ±4.
- en toggled 1,0,0,1 with order=1, din=0x4000 -> sdm_vld=0 and sdm_out held during en=0; the carry pattern resumes without skipped phase (4 enabled edges per 1).
- Reset mid-run: assert rst for 1 cycle during order=3 streaming -> next cycle all outputs 0, order_reg=3, and the sequence after release is bit-identical to the post-power-up run.
- dith_en=1, din=0, order=3 -> non-zero outputs appear; |sum sdm_out| over 4096 cycles ≤4. Order switch from 3 to 1 mid-stream -> the next sample is in 0..1 and acc2/acc3 read 0.

Source files
------------

// File: rtl/mash_sdm_pkg.sv
// Shared constants, order encoding and helpers for the MASH 1-1-1 modulator.
package mash_sdm_pkg;

  localparam int unsigned OUT_W      = 4;
  localparam int unsigned LFSR_W     = 23;
  localparam int unsigned LFSR_TAP_A = 23;
  localparam int unsigned LFSR_TAP_B = 18;

  typedef enum logic [1:0] {
    ORD1 = 2'd1,
    ORD2 = 2'd2,
    ORD3 = 2'd3
  } order_e;

  // Order code 0 is folded onto first order.
  function automatic order_e norm_order(input logic [1:0] ord);
    order_e res;
    case (ord)
      2'd2:    res = ORD2;
      2'd3:    res = ORD3;
      default: res = ORD1;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mash_acc_stage.sv
// One W-bit accumulator stage: registered sum, combinational next sum and carry-out.
module mash_acc_stage #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] addend,
  input  logic         cin,
  output logic [W-1:0] sum_c,
  output logic         co_c
);

  logic [W-1:0] acc;
  logic [W:0]   s_c;

  assign s_c   = {1'b0, acc} + {1'b0, addend} + {{W{1'b0}}, cin};
  assign sum_c = s_c[W-1:0];
  assign co_c  = s_c[W];

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (en) begin
      acc <= clr ? '0 : s_c[W-1:0];
    end
  end

endmodule

// File: rtl/mash_sdm_v2.sv
// Parametrised MASH 1-1-1 sigma-delta modulator with run-time order select,
// optional LFSR dither on the stage-1 carry-in and a clock-enable/valid handshake.
module mash_sdm_v2
  import mash_sdm_pkg::*;
#(
  parameter int unsigned       W         = 16,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 23'h5A5A5A
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    din_vld,
  input  logic [W-1:0]            din,
  input  logic [1:0]              order,
  input  logic                    dith_en,
  output logic signed [OUT_W-1:0] sdm_out,
  output logic                    sdm_vld,
  output logic                    sdm_qn
);

  logic [W-1:0]      din_reg;
  order_e            order_reg;
  logic [LFSR_W-1:0] lfsr;
  logic              c2_d1, c3_d1, c3_d2;

  order_e            ord_c;
  logic              act2_c, act3_c, drop2_c, drop3_c;
  logic              dith_c, qn_c, lfsr_fb_c;
  logic [OUT_W-1:0]  y_c;

  logic [W-1:0]      add_c       [1:3];
  logic [W-1:0]      sum_c       [1:3];
  logic              cin_c       [1:3];
  logic              carry_c     [1:3];
  logic              stage_en_c  [1:3];
  logic              stage_clr_c [1:3];

  assign ord_c     = norm_order(order);
  assign act2_c    = (ord_c != ORD1);
  assign act3_c    = (ord_c == ORD3);
  // Stages leaving the active set are zeroed once, then simply stop clocking.
  assign drop2_c   = !act2_c && (order_reg != ORD1);
  assign drop3_c   = !act3_c && (order_reg == ORD3);
  assign dith_c    = dith_en & lfsr[0];
  assign lfsr_fb_c = lfsr[LFSR_TAP_A-1] ^ lfsr[LFSR_TAP_B-1];

  always_comb begin
    add_c[1]       = din_reg;
    add_c[2]       = sum_c[1];
    add_c[3]       = sum_c[2];
    cin_c[1]       = dith_c;
    cin_c[2]       = 1'b0;
    cin_c[3]       = 1'b0;
    stage_en_c[1]  = en;
    stage_en_c[2]  = en & (act2_c | drop2_c);
    stage_en_c[3]  = en & (act3_c | drop3_c);
    stage_clr_c[1] = 1'b0;
    stage_clr_c[2] = drop2_c;
    stage_clr_c[3] = drop3_c;
  end

  for (genvar k = 1; k <= 3; k++) begin : g_stage
    mash_acc_stage #(.W(W)) u_stage (
      .clk    (clk),
      .rst    (rst),
      .en     (stage_en_c[k]),
      .clr    (stage_clr_c[k]),
      .addend (add_c[k]),
      .cin    (cin_c[k]),
      .sum_c  (sum_c[k]),
      .co_c   (carry_c[k])
    );
  end

  // Noise-shaping combine; modulo-16 arithmetic is exact since y stays in -3..+4.
  always_comb begin
    y_c = OUT_W'(carry_c[1]);
    if (act2_c) begin
      y_c = y_c + OUT_W'(carry_c[2]) - OUT_W'(c2_d1);
    end
    if (act3_c) begin
      y_c = y_c + OUT_W'(carry_c[3]) - OUT_W'({c3_d1, 1'b0}) + OUT_W'(c3_d2);
    end
  end

  always_comb begin
    case (ord_c)
      ORD2:    qn_c = sum_c[2][W-1];
      ORD3:    qn_c = sum_c[3][W-1];
      default: qn_c = sum_c[1][W-1];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      din_reg   <= '0;
      order_reg <= ORD3;
      lfsr      <= LFSR_SEED;
      c2_d1     <= 1'b0;
      c3_d1     <= 1'b0;
      c3_d2     <= 1'b0;
      sdm_out   <= '0;
      sdm_vld   <= 1'b0;
      sdm_qn    <= 1'b0;
    end else begin
      if (din_vld) begin
        din_reg <= din;
      end
      sdm_vld <= en;
      if (en) begin
        order_reg <= ord_c;
        sdm_out   <= y_c;
        sdm_qn    <= qn_c;
        lfsr      <= {lfsr[LFSR_W-2:0], lfsr_fb_c};
        if (act2_c) begin
          c2_d1 <= carry_c[2];
        end else if (drop2_c) begin
          c2_d1 <= 1'b0;
        end
        if (act3_c) begin
          c3_d1 <= carry_c[3];
          c3_d2 <= c3_d1;
        end else if (drop3_c) begin
          c3_d1 <= 1'b0;
          c3_d2 <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mash_sdm_v2.sv
// Scoreboard bench for mash_sdm_v2: a behavioural model predicts every output
// cycle, plus directed checks on patterns, ranges, means and reset replay.
module tb_mash_sdm_v2;

  localparam int W = 16;
  localparam longint MASK = (longint'(1) << W) - 1;

  logic              clk = 1'b0;
  logic              rst, en, din_vld, dith_en;
  logic [W-1:0]      din;
  logic [1:0]        order;
  logic signed [3:0] sdm_out;
  logic              sdm_vld, sdm_qn;

  always #5 clk = ~clk;

  mash_sdm_v2 #(.W(W), .LFSR_SEED(23'h5A5A5A)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .din_vld (din_vld),
    .din     (din),
    .order   (order),
    .dith_en (dith_en),
    .sdm_out (sdm_out),
    .sdm_vld (sdm_vld),
    .sdm_qn  (sdm_qn)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference model state
  longint      m_din, m_a1, m_a2, m_a3;
  int          m_c2d1, m_c3d1, m_c3d2, m_out, m_vld, m_qn;
  logic [22:0] m_lfsr;

  typedef struct {
    int out;
    int vld;
    int qn;
  } exp_t;
  exp_t sb_q[$];

  task automatic model_step();
    int o, d, c1, c2, c3, y;
    longint s1, s2, s3, top;
    if (rst) begin
      m_din = 0; m_a1 = 0; m_a2 = 0; m_a3 = 0;
      m_c2d1 = 0; m_c3d1 = 0; m_c3d2 = 0;
      m_out = 0; m_vld = 0; m_qn = 0;
      m_lfsr = 23'h5A5A5A;
    end else begin
      if (en) begin
        o  = (order == 2'd0) ? 1 : int'(order);
        d  = int'(dith_en & m_lfsr[0]);
        s1 = m_a1 + m_din + d;  c1 = int'(s1 >> W); s1 = s1 & MASK;
        s2 = m_a2 + s1;         c2 = int'(s2 >> W); s2 = s2 & MASK;
        s3 = m_a3 + s2;         c3 = int'(s3 >> W); s3 = s3 & MASK;
        y = c1;
        if (o >= 2) y = y + c2 - m_c2d1;
        if (o == 3) y = y + c3 - 2 * m_c3d1 + m_c3d2;
        top    = (o == 1) ? s1 : (o == 2) ? s2 : s3;
        m_qn   = int'((top >> (W - 1)) & 1);
        m_a1   = s1;
        m_a2   = (o >= 2) ? s2 : 0;
        m_a3   = (o == 3) ? s3 : 0;
        m_c3d2 = (o == 3) ? m_c3d1 : 0;
        m_c3d1 = (o == 3) ? c3 : 0;
        m_c2d1 = (o >= 2) ? c2 : 0;
        m_lfsr = {m_lfsr[21:0], m_lfsr[22] ^ m_lfsr[17]};
        m_out  = y;
        m_vld  = 1;
      end else begin
        m_vld = 0;
      end
      if (din_vld) m_din = longint'(din);
    end
  endtask

  // Predict, clock, then compare one cycle away from the edge.
  task automatic tick();
    exp_t e;
    model_step();
    sb_q.push_back('{m_out, m_vld, m_qn});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check_eq("sb_out", longint'(sdm_out), longint'(e.out));
    check_eq("sb_vld", longint'(sdm_vld), longint'(e.vld));
    check_eq("sb_qn",  longint'(sdm_qn),  longint'(e.qn));
  endtask

  int rec_a[48];
  int rec_b[48];

  task automatic replay_run(output int rec[48]);
    rst = 1'b0; en = 1'b1; order = 2'd3; dith_en = 1'b1;
    din = 16'h1234; din_vld = 1'b1;
    for (int i = 0; i < 48; i++) begin
      tick();
      din_vld = 1'b0;
      rec[i] = int'(sdm_out);
    end
  endtask

  initial begin
    int ne, held, sum, bad, nz;

    rst = 1'b1; en = 1'b0; din_vld = 1'b0; din = '0; order = 2'd3; dith_en = 1'b0;
    #1;
    tick();
    tick();
    check_eq("rst_out", longint'(sdm_out), 0);
    check_eq("rst_vld", longint'(sdm_vld), 0);
    check_eq("rst_qn", longint'(sdm_qn), 0);
    check_eq("rst_order_reg", longint'(dut.order_reg), 3);

    // First order, quarter-scale input: 0,0,0,1 repeating from the 2nd edge.
    rst = 1'b0; en = 1'b1; order = 2'd1; din = 16'h4000; din_vld = 1'b1;
    tick();
    din_vld = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      check_eq("pat1_out", longint'(sdm_out), (i % 4 == 3) ? 1 : 0);
      check_eq("pat1_vld", longint'(sdm_vld), 1);
    end

    // Enable gaps: output holds, phase continues without skipping.
    ne = 0; held = 0;
    for (int i = 0; i < 16; i++) begin
      en = (i % 4 == 0 || i % 4 == 3);
      tick();
      if (en) begin
        check_eq("gap_out", longint'(sdm_out), (ne % 4 == 3) ? 1 : 0);
        held = int'(sdm_out);
        ne++;
      end else begin
        check_eq("gap_vld", longint'(sdm_vld), 0);
        check_eq("gap_hold", longint'(sdm_out), longint'(held));
      end
    end

    // Third order, zero input: output and qn stay zero.
    rst = 1'b1; en = 1'b1; tick();
    rst = 1'b0; order = 2'd3; din = '0; din_vld = 1'b1;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      din_vld = 1'b0;
      if (sdm_out != 0 || sdm_qn != 1'b0) bad++;
    end
    check_eq("zero_run", longint'(bad), 0);

    // Half-scale, third order: bounded samples, mean one half.
    din = 16'h8000; din_vld = 1'b1;
    tick();
    din_vld = 1'b0;
    sum = 0; bad = 0;
    for (int i = 0; i < 1024; i++) begin
      tick();
      sum += int'(sdm_out);
      if (sdm_out < -3 || sdm_out > 4) bad++;
    end
    check_eq("half_range", longint'(bad), 0);
    check_eq("half_sum_ok", longint'(sum >= 508 && sum <= 516), 1);

    // Reset replay: sequence after a mid-run reset matches the first one.
    rst = 1'b1; tick();
    replay_run(rec_a);
    din = 16'hBEEF; din_vld = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      din_vld = 1'b0;
    end
    rst = 1'b1; din_vld = 1'b1; din = 16'hFFFF;
    tick();
    check_eq("mid_rst_out", longint'(sdm_out), 0);
    check_eq("mid_rst_vld", longint'(sdm_vld), 0);
    check_eq("mid_rst_qn", longint'(sdm_qn), 0);
    check_eq("mid_rst_order_reg", longint'(dut.order_reg), 3);
    replay_run(rec_b);
    for (int i = 0; i < 48; i++) begin
      check_eq("replay", longint'(rec_b[i]), longint'(rec_a[i]));
    end

    // Dither only, third order: activity, bounded sum.
    rst = 1'b1; tick();
    rst = 1'b0; order = 2'd3; din = '0; din_vld = 1'b1; dith_en = 1'b1;
    sum = 0; bad = 0; nz = 0;
    for (int i = 0; i < 4096; i++) begin
      tick();
      din_vld = 1'b0;
      sum += int'(sdm_out);
      if (sdm_out != 0) nz++;
      if (sdm_out < -3 || sdm_out > 4) bad++;
    end
    check_eq("dith_nonzero", longint'(nz > 0), 1);
    check_eq("dith_range", longint'(bad), 0);
    check_eq("dith_sum_ok", longint'(sum >= -4 && sum <= 4), 1);

    // Drop from third to first order mid-stream.
    order = 2'd1;
    tick();
    check_eq("drop_range", longint'(sdm_out >= 0 && sdm_out <= 1), 1);
    check_eq("drop_acc2", longint'(dut.g_stage[2].u_stage.acc), 0);
    check_eq("drop_acc3", longint'(dut.g_stage[3].u_stage.acc), 0);

    // Order code 0 and a climb back to second order.
    din = 16'h3333; din_vld = 1'b1; dith_en = 1'b0;
    order = 2'd0;
    for (int i = 0; i < 8; i++) begin
      tick();
      din_vld = 1'b0;
      check_eq("ord0_range", longint'(sdm_out >= 0 && sdm_out <= 1), 1);
    end
    order = 2'd2;
    for (int i = 0; i < 32; i++) begin
      tick();
      check_eq("ord2_range", longint'(sdm_out >= -1 && sdm_out <= 2), 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
